nn_sample_driver: RTL and testbench

NN_SAMPLE_DRIVER -- requirements
Module: nn_sample_driver

---
 rtl/nn_sample_driver.sv | 162 ++++++++++++++++
 tb/tb_nn_sample_driver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_sample_driver.sv
// Double-buffered sample driver: streams words into a shadow buffer and launches the network per sample.
// Optional WAIT-state timeout enabled by defining NN_DRV_TIMEOUT_EN.
module nn_sample_driver #(
   parameter int unsigned N_INPUTS       = 784,
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned RESULT_WIDTH   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16384
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           pix_valid,
   input  logic [DATA_WIDTH-1:0]          pix_data,
   input  logic                           pix_last,
   output logic                           pix_ready,
   output logic [N_INPUTS*DATA_WIDTH-1:0] net_in,
   output logic                           net_first,
   input  logic                           net_done,
   input  logic [RESULT_WIDTH-1:0]        net_result,
   output logic                           res_valid,
   input  logic                           res_ready,
   output logic [RESULT_WIDTH-1:0]        res_data,
   output logic                           busy,
   output logic                           err,
   output logic [15:0]                    sample_count
);

   localparam int unsigned BUF_W  = N_INPUTS * DATA_WIDTH;
   localparam int unsigned WCNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(N_INPUTS - 1);

`ifdef NN_DRV_TIMEOUT_EN
   localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TCNT_W-1:0] TO_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
   logic [TCNT_W-1:0] tcnt_q, tcnt_d;
`endif

   typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_HOLD} state_t;

   state_t                  state_q, state_d;
   logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
   logic                    shadow_full_q, shadow_full_d;
   logic [BUF_W-1:0]        shadow_q, shadow_d;
   logic [BUF_W-1:0]        net_in_q, net_in_d;
   logic                    net_first_q, net_first_d;
   logic                    res_valid_q, res_valid_d;
   logic [RESULT_WIDTH-1:0] res_data_q, res_data_d;
   logic                    err_q, err_d;
   logic [15:0]             sample_count_q, sample_count_d;
   logic                    accept;
   logic                    at_last;

   always_comb begin
      state_d        = state_q;
      wcnt_d         = wcnt_q;
      shadow_full_d  = shadow_full_q;
      shadow_d       = shadow_q;
      net_in_d       = net_in_q;
      net_first_d    = 1'b0;
      res_valid_d    = res_valid_q;
      res_data_d     = res_data_q;
      err_d          = 1'b0;
      sample_count_d = sample_count_q;
      accept         = pix_valid && !shadow_full_q;
      at_last        = (wcnt_q == LAST_IDX);
`ifdef NN_DRV_TIMEOUT_EN
      tcnt_d         = '0;
`endif

      // Fill side runs independently of the launch FSM; a malformed sample is dropped whole.
      if (accept) begin
         shadow_d[wcnt_q*DATA_WIDTH +: DATA_WIDTH] = pix_data;
         if (pix_last && at_last) begin
            shadow_full_d = 1'b1;
            wcnt_d        = '0;
         end else if (pix_last || at_last) begin
            wcnt_d = '0;
            err_d  = 1'b1;
         end else begin
            wcnt_d = wcnt_q + 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (shadow_full_q) begin
               net_in_d      = shadow_q;
               shadow_full_d = 1'b0;
               state_d       = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            net_first_d = 1'b1;
            state_d     = ST_WAIT;
         end
         ST_WAIT: begin
            if (net_done) begin
               res_data_d     = net_result;
               res_valid_d    = 1'b1;
               sample_count_d = sample_count_q + 16'd1;
               state_d        = ST_HOLD;
            end
`ifdef NN_DRV_TIMEOUT_EN
            else if (tcnt_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
`endif
         end
         ST_HOLD: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         wcnt_q         <= '0;
         shadow_full_q  <= 1'b0;
         shadow_q       <= '0;
         net_in_q       <= '0;
         net_first_q    <= 1'b0;
         res_valid_q    <= 1'b0;
         res_data_q     <= '0;
         err_q          <= 1'b0;
         sample_count_q <= '0;
`ifdef NN_DRV_TIMEOUT_EN
         tcnt_q         <= '0;
`endif
      end else begin
         state_q        <= state_d;
         wcnt_q         <= wcnt_d;
         shadow_full_q  <= shadow_full_d;
         shadow_q       <= shadow_d;
         net_in_q       <= net_in_d;
         net_first_q    <= net_first_d;
         res_valid_q    <= res_valid_d;
         res_data_q     <= res_data_d;
         err_q          <= err_d;
         sample_count_q <= sample_count_d;
`ifdef NN_DRV_TIMEOUT_EN
         tcnt_q         <= tcnt_d;
`endif
      end
   end

   assign pix_ready    = !shadow_full_q;
   assign net_in       = net_in_q;
   assign net_first    = net_first_q;
   assign res_valid    = res_valid_q;
   assign res_data     = res_data_q;
   assign err          = err_q;
   assign sample_count = sample_count_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nn_sample_driver.sv
// Directed self-checking bench for nn_sample_driver with N_INPUTS=4, DATA_WIDTH=16.
module tb_nn_sample_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pix_valid;
   logic [15:0] pix_data;
   logic        pix_last;
   logic        pix_ready;
   logic [63:0] net_in;
   logic        net_first;
   logic        net_done;
   logic [3:0]  net_result;
   logic        res_valid;
   logic        res_ready;
   logic [3:0]  res_data;
   logic        busy;
   logic        err;
   logic [15:0] sample_count;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   nn_sample_driver #(
      .N_INPUTS      (4),
      .DATA_WIDTH    (16),
      .RESULT_WIDTH  (4),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .pix_last    (pix_last),
      .pix_ready   (pix_ready),
      .net_in      (net_in),
      .net_first   (net_first),
      .net_done    (net_done),
      .net_result  (net_result),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .busy        (busy),
      .err         (err),
      .sample_count(sample_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic send_word(input logic [15:0] d, input logic l);
      bit ok = 1'b0;
      pix_valid = 1'b1;
      pix_data  = d;
      pix_last  = l;
      for (int i = 0; i < 100; i++) begin
         if (pix_ready) begin
            @(posedge clk);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check("send_timeout", 64'd0, 64'd1);
      @(negedge clk);
      pix_valid = 1'b0;
      pix_last  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; pix_valid = 1'b0; pix_data = '0; pix_last = 1'b0;
      net_done = 1'b0; net_result = '0; res_ready = 1'b0;

      @(negedge clk);
      check("rst_pix_ready", pix_ready, 1);
      check("rst_net_in", net_in, 0);
      check("rst_net_first", net_first, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 0);
      check("rst_count", sample_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // basic sample and launch latency
      send_word(16'h0001, 1'b0);
      send_word(16'h0002, 1'b0);
      send_word(16'h0003, 1'b0);
      send_word(16'h0004, 1'b1);
      check("s1_full_ready", pix_ready, 0);
      check("s1_idle_busy", busy, 0);
      check("s1_net_in_pre", net_in, 0);
      @(negedge clk);
      check("s1_net_in", net_in, 64'h0004_0003_0002_0001);
      check("s1_first_early", net_first, 0);
      check("s1_busy", busy, 1);
      check("s1_ready_back", pix_ready, 1);
      @(negedge clk);
      check("s1_first", net_first, 1);
      @(negedge clk);
      check("s1_first_end", net_first, 0);

      // result hold under backpressure
      net_done = 1'b1; net_result = 4'd7;
      @(negedge clk);
      net_done = 1'b0; net_result = 4'd0;
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", res_valid, 1);
         check("hold_data", res_data, 7);
         @(negedge clk);
      end
      check("hold_count", sample_count, 1);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("rel_valid", res_valid, 0);
      check("rel_busy", busy, 0);
      check("rel_count", sample_count, 1);

      // net_done while idle is ignored
      net_done = 1'b1; net_result = 4'd2;
      @(negedge clk);
      net_done = 1'b0;
      check("idle_done_valid", res_valid, 0);
      check("idle_done_count", sample_count, 1);
      check("idle_done_busy", busy, 0);

      // early pix_last -> err, then clean sample
      send_word(16'h0011, 1'b0);
      send_word(16'h0012, 1'b1);
      check("short_err", err, 1);
      check("short_ready", pix_ready, 1);
      @(negedge clk);
      check("short_err_end", err, 0);
      check("short_no_first", net_first, 0);
      check("short_busy", busy, 0);
      send_word(16'h000A, 1'b0);
      send_word(16'h000B, 1'b0);
      send_word(16'h000C, 1'b0);
      send_word(16'h000D, 1'b1);
      check("s2_err", err, 0);
      @(negedge clk);
      check("s2_net_in", net_in, 64'h000D_000C_000B_000A);
      @(negedge clk);
      check("s2_first", net_first, 1);

      // next sample streamed during WAIT
      send_word(16'h0021, 1'b0);
      send_word(16'h0022, 1'b0);
      send_word(16'h0023, 1'b0);
      send_word(16'h0024, 1'b1);
      for (int i = 0; i < 3; i++) begin
         check("s3_ready_low", pix_ready, 0);
         check("s3_net_in_kept", net_in, 64'h000D_000C_000B_000A);
         @(negedge clk);
      end
      net_done = 1'b1; net_result = 4'd3;
      @(negedge clk);
      net_done = 1'b0;
      check("s3_res_valid", res_valid, 1);
      check("s3_res_data", res_data, 3);
      check("s3_count", sample_count, 2);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("s3_released", res_valid, 0);
      check("s3_net_in_hold", net_in, 64'h000D_000C_000B_000A);
      check("s3_ready_still", pix_ready, 0);
      @(negedge clk);
      check("s3_net_in", net_in, 64'h0024_0023_0022_0021);
      check("s3_ready_back", pix_ready, 1);
      check("s3_first_early", net_first, 0);
      @(negedge clk);
      check("s3_first", net_first, 1);

      // reset during WAIT with a partial sample in flight
      send_word(16'h0031, 1'b0);
      send_word(16'h0032, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_net_in", net_in, 0);
      check("mid_rst_first", net_first, 0);
      check("mid_rst_valid", res_valid, 0);
      check("mid_rst_data", res_data, 0);
      check("mid_rst_err", err, 0);
      check("mid_rst_ready", pix_ready, 1);
      check("mid_rst_count", sample_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      net_done = 1'b1; net_result = 4'd5;
      @(negedge clk);
      net_done = 1'b0;
      check("post_rst_valid", res_valid, 0);
      check("post_rst_err", err, 0);
      check("post_rst_count", sample_count, 0);
      send_word(16'h0041, 1'b0);
      send_word(16'h0042, 1'b0);
      send_word(16'h0043, 1'b0);
      send_word(16'h0044, 1'b1);
      check("s4_err", err, 0);
      @(negedge clk);
      check("s4_net_in", net_in, 64'h0044_0043_0042_0041);
      @(negedge clk);
      check("s4_first", net_first, 1);

`ifdef NN_DRV_TIMEOUT_EN
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         check("to_err_early", err, 0);
         check("to_busy", busy, 1);
      end
      @(negedge clk);
      check("to_err", err, 1);
      check("to_idle", busy, 0);
      check("to_count", sample_count, 0);
      @(negedge clk);
      check("to_err_end", err, 0);
      check("to_no_result", res_valid, 0);
`else
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("wait_busy", busy, 1);
         check("wait_err", err, 0);
      end
      net_done = 1'b1; net_result = 4'd9;
      @(negedge clk);
      net_done = 1'b0;
      check("s4_res_data", res_data, 9);
      check("s4_count", sample_count, 1);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("s4_idle", busy, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
